// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one word mux between DEPTH valid/ready requesters,
// presenting the granted word on a single registered valid/ready output port.

module param_mux #(
   parameter int DEPTH     = 4,
   parameter int WORD_SIZE = 8
) (
   input  logic [$clog2(DEPTH)-1:0] sel,
   input  logic [WORD_SIZE-1:0]     data [DEPTH-1:0],
   output logic [WORD_SIZE-1:0]     y
);

   localparam int IW = $clog2(DEPTH);

   // Compare against each legal index so select codes >= DEPTH read zero
   always_comb begin
      y = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (sel == IW'(k)) begin
            y = data[k];
         end
      end
   end

endmodule

module rr_mux_arbiter #(
   parameter int DEPTH     = 4,
   parameter int WORD_SIZE = 8
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [DEPTH-1:0]         i_req_valid,
   input  logic [WORD_SIZE-1:0]     i_req_data [DEPTH-1:0],
   output logic [DEPTH-1:0]         o_req_ready,
   output logic                     o_valid,
   output logic [WORD_SIZE-1:0]     o_data,
   input  logic                     i_ready,
   output logic [$clog2(DEPTH)-1:0] o_grant_idx
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic {
      IDLE,
      SEND
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [IW-1:0]       last_grant;
   logic [IW-1:0]       winner;
   logic [IW:0]         cand;
   logic                any_valid;
   logic                can_load;
   logic                load;
   logic [WORD_SIZE-1:0] mux_word;

   // Search starts one past the last grant; the candidate is one bit wider so
   // the sum can be wrapped at DEPTH rather than at the next power of two.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      cand      = '0;
      for (int unsigned off = 1; off <= DEPTH; off++) begin
         cand = {1'b0, last_grant} + (IW + 1)'(off);
         if (cand >= (IW + 1)'(DEPTH)) begin
            cand = cand - (IW + 1)'(DEPTH);
         end
         if (!any_valid && i_req_valid[cand[IW-1:0]]) begin
            any_valid = 1'b1;
            winner    = cand[IW-1:0];
         end
      end
   end

   param_mux #(
      .DEPTH     (DEPTH),
      .WORD_SIZE (WORD_SIZE)
   ) u_mux (
      .sel  (winner),
      .data (i_req_data),
      .y    (mux_word)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_next = SEND;
            end
         end
         SEND: begin
            if (i_ready && !any_valid) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      o_valid     = (state == SEND);
      can_load    = (state == IDLE) || (o_valid && i_ready);
      load        = can_load && any_valid && !i_rst;
      o_req_ready = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         o_req_ready[k] = load && (winner == IW'(k));
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_data      <= '0;
         o_grant_idx <= '0;
         last_grant  <= LAST_IDX;
      end else if (load) begin
         o_data      <= mux_word;
         o_grant_idx <= winner;
         last_grant  <= winner;
      end
   end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
Round-robin arbiter and sequencer that shares one parameterized word mux (param_mux) between DEPTH requesters.
Each requester offers a word with a valid/ready handshake. The block grants one requester per transfer, steers the mux select, and presents the chosen word on a single registered valid/ready output port.
It sits in front of any single-consumer resource that several producers must time-share.

Parameters:
DEPTH, 4, number of requesters; legal range 2..16, any value (power of two not required)
WORD_SIZE, 8, data word width in bits

Ports:
i_clk  input  1  single clock; all state updates on rising edge
i_rst  input  1  synchronous reset, active-high
i_req_valid  input  DEPTH  per-requester valid; bit k belongs to requester k
i_req_data  input  WORD_SIZE x DEPTH (unpacked array [DEPTH-1:0])  per-requester data word
o_req_ready  output  DEPTH  per-requester accept; one-hot or all-zero
o_valid  output  1  output word valid
o_data  output  WORD_SIZE  output word (registered)
i_ready  input  1  downstream accept
o_grant_idx  output  $clog2(DEPTH)  index of requester whose word is in o_data

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - state=IDLE; o_valid=0; o_data=0; o_grant_idx=0; last_grant=DEPTH-1, so requester 0 wins first.
  - o_req_ready is forced to all-zero while i_rst=1.
  - Reset mid-transfer discards the held word. No requester is acknowledged in the reset cycle.
- Transfer definitions:
  - Requester transfer: i_req_valid[k] && o_req_ready[k] at a clock edge.
  - Output transfer: o_valid && i_ready at a clock edge.
- Arbitration (combinational):
  - Search order: last_grant+1, last_grant+2, ..., wrapping DEPTH-1 -> 0, ending at last_grant.
  - The first index with i_req_valid set is the winner. A requester at last_grant is considered last.
- can_load = (state==IDLE) || (o_valid && i_ready).
- o_req_ready[winner] = can_load && any valid. All other bits are 0. No requester is acknowledged when can_load=0.
- Mux: a param_mux instance with DEPTH/WORD_SIZE, select=winner index, feeds the o_data register input.
- FSM states and transitions:
  - IDLE: o_valid=0.
    - Any valid: load o_data from the mux, set o_grant_idx=winner and last_grant=winner, go SEND.
    - No valid: stay IDLE.
  - SEND: o_valid=1; o_data and o_grant_idx held stable.
    - i_ready=0: stay SEND, hold everything. Requesters are not acknowledged.
    - i_ready=1 with any valid: reload with the new winner in the same edge, stay SEND. This gives back-to-back throughput of 1 word/cycle.
    - i_ready=1 with no valid: go IDLE; o_valid=0 next cycle. o_data keeps its last value.
- Latency: request at edge N (IDLE) -> o_valid=1 with the word after edge N, i.e. 1 cycle.
- Fairness: with all DEPTH requesters continuously valid and i_ready=1, grants cycle 0,1,...,DEPTH-1,0,...
  - No requester waits more than DEPTH-1 output transfers once it holds valid.
- Requester rules: a requester must hold valid/data stable until acknowledged. Deasserting valid early is tolerated; it simply loses arbitration.
- Non-power-of-two DEPTH: the pointer wraps at DEPTH-1, never at 2^clog2 - 1. Indices >= DEPTH are never granted.

Test Plan:
1. Reset with all requesters valid -> after release, first grant is requester 0. o_valid=0, o_data=0, o_req_ready=0 during reset.
2. DEPTH=4, WORD_SIZE=8, requesters 0..3 hold data 0x10,0x21,0x32,0x43, all valid, i_ready=1 -> o_data sequence 0x10,0x21,0x32,0x43,0x10 on consecutive cycles; o_grant_idx 0,1,2,3,0.
3. Only requester 2 valid, data 0xA5, i_ready=1 -> o_req_ready=4'b0100 for one cycle; o_valid=1, o_data=0xA5 next cycle; then o_valid=0 once valid drops.
4. Backpressure: word 0x10 loaded, i_ready=0 for 5 cycles with requester 1 valid -> o_data stays 0x10, o_req_ready=0 throughout. i_ready=1 -> 0x21 appears next cycle.
5. DEPTH=3, all valid, i_ready=1 for 7 transfers -> grants 0,1,2,0,1,2,0; never index 3.
6. Reset asserted while in SEND holding 0x32 -> next cycle o_valid=0, o_data=0, no o_req_ready pulse. After release, grant restarts at requester 0.
